// File: rtl/uram_pipe_memory.sv
// uram_pipe_memory
//
// Single-clock simple-dual-port memory with byte write enables, a fully
// pipelined read path of fixed latency, and a zero-sweep controller that
// clears the array after reset (optional) or on request.
//
// Parameters
//   DATA_WIDTH     read/write word width, multiple of 8
//   ADDRESS_WIDTH  depth is 2**ADDRESS_WIDTH words
//   READ_LATENCY   cycles from read issue to dout_valid (1..8)
//   CLEAR_ON_RESET 1: zero-sweep the array after reset release
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   ren/raddr   read request and address
//   dout        read data, held between completed reads
//   dout_valid  dout carries a completed read this cycle
//   wen/wbe     write request and byte enables (bit i -> bits 8i+7:8i)
//   waddr/din   write address and data
//   clear_req   single-cycle request to re-run the zero sweep
//   init_done   high when user reads and writes are accepted

module uram_pipe_memory #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDRESS_WIDTH  = 12,
    parameter int unsigned READ_LATENCY   = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      ren,
    input  logic [ADDRESS_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid,
    input  logic                      wen,
    input  logic [DATA_WIDTH/8-1:0]   wbe,
    input  logic [ADDRESS_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      clear_req,
    output logic                      init_done
);

    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] SWEEP_LAST = '1;

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    state_e                     state_q;
    logic [ADDRESS_WIDTH-1:0]   sweep_q;
    logic                       init_done_q;

    logic                       rd_accept;
    logic                       wr_accept;
    logic [DATA_WIDTH-1:0]      rd_word;

    logic [DATA_WIDTH-1:0]      mem [DEPTH];

    logic [READ_LATENCY-1:0]    rd_valid_q;
    logic [DATA_WIDTH-1:0]      rd_data_q [READ_LATENCY];

    // User traffic is only honoured once the controller reports ready.
    assign rd_accept = ren & init_done_q;
    assign wr_accept = wen & init_done_q;

    // ------------------------------------------------------------------
    // Sweep controller. init_done is registered alongside the state so it
    // rises on the same edge that leaves CLEAR and drops on the edge that
    // enters it.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if (CLEAR_ON_RESET) begin
                state_q <= StClear;
            end else begin
                state_q <= StReady;
            end
            sweep_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    // Counter wraps to zero after the last address, so it
                    // is already at 0 for any later sweep. clear_req is
                    // deliberately not looked at here.
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == SWEEP_LAST) begin
                        state_q     <= StReady;
                        init_done_q <= 1'b1;
                    end
                end
                StReady: begin
                    if (clear_req) begin
                        state_q     <= StClear;
                        sweep_q     <= '0;
                        init_done_q <= 1'b0;
                    end else begin
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StClear;
                    sweep_q     <= '0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage. Not reset: contents are only zeroed by the sweep.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (state_q == StClear) begin
            mem[sweep_q] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= din[8*b +: 8];
                end
            end
        end
    end

    // Write-first bypass: enabled bytes of a same-cycle write to the read
    // address replace the stored bytes in the returned word.
    always_comb begin
        rd_word = mem[raddr];
        if (wr_accept && (waddr == raddr)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wbe[b]) begin
                    rd_word[8*b +: 8] = din[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 0 captures at the issue edge; the last stage is
    // the output register. Data in each stage only moves with a valid
    // token, so dout holds its last completed value between reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                rd_data_q[k] <= '0;
            end
        end else begin
            rd_valid_q[0] <= rd_accept;
            if (rd_accept) begin
                rd_data_q[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                rd_valid_q[k] <= rd_valid_q[k-1];
                if (rd_valid_q[k-1]) begin
                    rd_data_q[k] <= rd_data_q[k-1];
                end
            end
        end
    end

    assign dout       = rd_data_q[READ_LATENCY-1];
    assign dout_valid = rd_valid_q[READ_LATENCY-1];
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_uram_pipe_memory.sv
// Self-checking bench for uram_pipe_memory (32-bit words, 16 deep,
// latency 3). A cycle-level reference model (array + queue of pending
// reads with due cycles) is checked every cycle; directed tables and
// sequences cover the multi-cycle corner cases.

module tb_uram_pipe_memory;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int L     = 3;
    localparam int DEPTH = 16;

    logic            clock     = 1'b0;
    logic            reset_n   = 1'b0;
    logic            ren       = 1'b0;
    logic [AW-1:0]   raddr     = '0;
    logic            wen       = 1'b0;
    logic [DW/8-1:0] wbe       = '0;
    logic [AW-1:0]   waddr     = '0;
    logic [DW-1:0]   din       = '0;
    logic            clear_req = 1'b0;
    logic [DW-1:0]   dout;
    logic            dout_valid;
    logic            init_done;

    uram_pipe_memory #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .READ_LATENCY  (L),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ren       (ren),
        .raddr     (raddr),
        .dout      (dout),
        .dout_valid(dout_valid),
        .wen       (wen),
        .wbe       (wbe),
        .waddr     (waddr),
        .din       (din),
        .clear_req (clear_req),
        .init_done (init_done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct {
        int          due;
        logic [31:0] d;
    } rd_t;

    logic [31:0] mmem [DEPTH];
    rd_t         mq [$];
    bit          m_ready = 1'b0;
    int          m_left  = DEPTH;
    bit          m_valid = 1'b0;
    logic [31:0] m_dout  = '0;
    int          cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // One clock: advance the model with the inputs sampled at the edge, then
    // compare all outputs just after the edge.
    task automatic step();
        rd_t         e;
        logic [31:0] v;
        @(posedge clock);
        cyc++;
        if (reset_n) begin
            if (m_ready && ren) begin
                v = mmem[raddr];
                if (wen && waddr == raddr) v = merge(v, din, wbe);
                e.due = cyc + L - 1;
                e.d   = v;
                mq.push_back(e);
            end
            if (m_ready && wen) mmem[waddr] = merge(mmem[waddr], din, wbe);
            if (!m_ready) begin
                mmem[DEPTH - m_left] = '0;
                m_left--;
                if (m_left == 0) m_ready = 1'b1;
            end else if (clear_req) begin
                m_ready = 1'b0;
                m_left  = DEPTH;
            end
            m_valid = 1'b0;
            if (mq.size() > 0 && mq[0].due == cyc) begin
                m_valid = 1'b1;
                m_dout  = mq[0].d;
                void'(mq.pop_front());
            end
        end
        #1;
        check("init_done", {31'b0, init_done}, {31'b0, m_ready});
        check("dout_valid", {31'b0, dout_valid}, {31'b0, m_valid});
        check("dout", dout, m_dout);
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        mq.delete();
        m_ready = 1'b0;
        m_left  = DEPTH;
        m_valid = 1'b0;
        m_dout  = '0;
        #1;
        check("reset_dout", dout, 32'h0);
        check("reset_dout_valid", {31'b0, dout_valid}, 32'h0);
        check("reset_init_done", {31'b0, init_done}, 32'h0);
    endtask

    // Called after the issue step; lat counts that step as 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!dout_valid && lat < 12) begin
            step();
            lat++;
        end
    endtask

    task automatic idle_inputs();
        ren = 1'b0; wen = 1'b0; clear_req = 1'b0; wbe = '0;
    endtask

    typedef struct {
        bit          same;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [6];
        int          lat;
        int          n;
        int          nv;
        logic [31:0] got [$];
        int          first_s;
        int          last_s;

        tbl[0] = '{1'b0, 4'd3, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 4'd7, 4'b1111, 32'h11223344, 32'h11223344};
        tbl[2] = '{1'b1, 4'd7, 4'b0101, 32'hAABBCCDD, 32'h11BB33DD};
        tbl[3] = '{1'b1, 4'd7, 4'b0000, 32'hFFFFFFFF, 32'h11BB33DD};
        tbl[4] = '{1'b0, 4'd3, 4'b1000, 32'h12345678, 32'h12ADBEEF};
        tbl[5] = '{1'b1, 4'd9, 4'b0010, 32'h0000AB00, 32'h0000AB00};

        // Reset held, then released: sweep must take 16 cycles.
        step();
        step();
        reset_n = 1'b1;
        n = 0;
        while (!init_done && n < 40) begin
            step();
            n++;
        end
        check("init_sweep_cycles", n, 16);

        ren = 1'b1; raddr = 4'd5;
        step();
        ren = 1'b0;
        wait_valid(lat);
        check("read5_latency", lat, L);
        check("read5_data", dout, 32'h0);

        // Directed write/read table.
        foreach (tbl[i]) begin
            wen = 1'b1; waddr = tbl[i].addr; wbe = tbl[i].be; din = tbl[i].data;
            if (tbl[i].same) begin
                ren = 1'b1; raddr = tbl[i].addr;
                step();
                idle_inputs();
            end else begin
                step();
                idle_inputs();
                ren = 1'b1; raddr = tbl[i].addr;
                step();
                ren = 1'b0;
            end
            wait_valid(lat);
            check($sformatf("tbl%0d_latency", i), lat, L);
            check($sformatf("tbl%0d_data", i), dout, tbl[i].exp);
            step();
        end

        // Back-to-back reads return in order with no bubbles.
        for (int i = 0; i < 4; i++) begin
            wen = 1'b1; wbe = 4'hF; waddr = 4'(i); din = 32'hA0 + 32'(i);
            step();
        end
        idle_inputs();
        n = 0; first_s = -1; last_s = -1;
        for (int i = 0; i < 12; i++) begin
            ren = (i < 4); raddr = 4'(i);
            step();
            n++;
            if (dout_valid) begin
                got.push_back(dout);
                if (first_s < 0) first_s = n;
                last_s = n;
            end
        end
        ren = 1'b0;
        check("burst_count", got.size(), 4);
        check("burst_span", last_s - first_s, 3);
        if (got.size() == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("burst%0d", i), got[i], 32'hA0 + 32'(i));
        end

        // Randomized traffic with occasional clear requests.
        for (int i = 0; i < 700; i++) begin
            ren       = ($urandom_range(0, 3) != 0);
            raddr     = 4'($urandom_range(0, 15));
            wen       = ($urandom_range(0, 2) != 0);
            waddr     = ($urandom_range(0, 2) == 0) ? raddr : 4'($urandom_range(0, 15));
            wbe       = 4'($urandom_range(0, 15));
            din       = $urandom;
            clear_req = ($urandom_range(0, 63) == 0);
            step();
        end
        idle_inputs();
        n = 0;
        while ((!init_done || n < 6) && n < 60) begin
            step();
            n++;
        end
        check("random_drain_ready", {31'b0, init_done}, 32'h1);

        // Clear with reads held high; a second clear_req mid-sweep is ignored.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        ren = 1'b1; raddr = 4'd3;
        n = init_done ? 0 : 1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            clear_req = (i == 5);
            step();
            if (dout_valid) nv++;
            if (init_done) break;
            n++;
        end
        idle_inputs();
        check("clear_low_cycles", n, 16);
        check("clear_no_valid", nv, 0);
        ren = 1'b1; raddr = 4'd3;
        step();
        ren = 1'b0;
        wait_valid(lat);
        check("post_clear_latency", lat, L);
        check("post_clear_data", dout, 32'h0);

        // Reset one cycle after a read issue discards the read.
        wen = 1'b1; wbe = 4'hF; waddr = 4'd2; din = 32'h5A5A5A5A;
        step();
        idle_inputs();
        ren = 1'b1; raddr = 4'd2;
        step();
        ren = 1'b0;
        wait_valid(lat);
        check("pre_reset_data", dout, 32'h5A5A5A5A);
        step();
        ren = 1'b1; raddr = 4'd2;
        step();
        ren = 1'b0;
        assert_reset();
        step();
        step();
        reset_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (dout_valid) nv++;
        end
        check("post_reset_no_valid", nv, 0);
        check("post_reset_ready", {31'b0, init_done}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uram_pipe_memory.md
URAM_PIPE_MEMORY -- requirements
Module: uram_pipe_memory

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, read/write data width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 12, giving depth 2^ADDRESS_WIDTH words.
REQ-003 The block SHALL have parameter READ_LATENCY, default 2, legal range 1..8, the cycles from read issue to data.
REQ-004 The block SHALL have parameter CLEAR_ON_RESET, default 1; when it is 1, the memory SHALL be zero-swept after reset release.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port ren, input, 1 bit: read request.
REQ-008 The block SHALL have port raddr, input, ADDRESS_WIDTH bits: read address.
REQ-009 The block SHALL have port dout, output, DATA_WIDTH bits: read data.
REQ-010 The block SHALL have port dout_valid, output, 1 bit: dout carries a completed read this cycle.
REQ-011 The block SHALL have port wen, input, 1 bit: write request.
REQ-012 The block SHALL have port wbe, input, DATA_WIDTH/8 bits: byte write enables; bit i controls bits 8i+7:8i.
REQ-013 The block SHALL have port waddr, input, ADDRESS_WIDTH bits: write address.
REQ-014 The block SHALL have port din, input, DATA_WIDTH bits: write data.
REQ-015 The block SHALL have port clear_req, input, 1 bit: single-cycle request to re-run the zero sweep.
REQ-016 The block SHALL have port init_done, output, 1 bit: high when the block accepts user reads and writes.

Function
REQ-017 The controller SHALL have two states, CLEAR and READY.
REQ-018 CLEAR SHALL write zero to every address, one per cycle, from 0 to 2^ADDRESS_WIDTH-1, using an ADDRESS_WIDTH-bit sweep counter.
REQ-019 CLEAR SHALL last exactly 2^ADDRESS_WIDTH cycles; the state SHALL then go to READY and init_done SHALL rise on the following cycle.
REQ-020 On reset release with CLEAR_ON_RESET=1, the state SHALL be CLEAR with the counter at 0.
REQ-021 On reset release with CLEAR_ON_RESET=0, the state SHALL be READY and init_done SHALL rise at the first clock edge after release.
REQ-022 clear_req in READY SHALL move the state to CLEAR at the next edge with the counter at 0, and init_done SHALL drop that same edge.
REQ-023 clear_req while in CLEAR SHALL be ignored, with no restart of the sweep.
REQ-024 While init_done=0, ren and wen SHALL be ignored: no memory update and no dout_valid generated.
REQ-025 A read accepted at edge t (ren=1, init_done=1) SHALL produce dout_valid=1 with its data exactly READ_LATENCY cycles later, for one cycle.
REQ-026 Reads SHALL be fully pipelined: one read per cycle, returned in issue order, with no bubbles.
REQ-027 Reads in flight when CLEAR starts SHALL complete normally, returning the contents as of their issue cycle.
REQ-028 dout SHALL update only on cycles where dout_valid=1, and SHALL hold its last value otherwise.
REQ-029 A write accepted at edge t SHALL update only the bytes whose wbe bit is 1; wbe all-zero SHALL leave the word unchanged.
REQ-030 Reads issued at t+1 or later SHALL observe a write accepted at edge t.
REQ-031 On a same-cycle read and write to the same address, the read SHALL be write-first: bytes with wbe set come from din, all other bytes hold the prior contents.
REQ-032 On a same-cycle read and write to different addresses, each SHALL proceed independently.

Reset
REQ-033 Assertion of reset_n=0 SHALL, immediately and without a clock, force dout=0, dout_valid=0, init_done=0, and clear all read-pipeline valid bits and the sweep counter.
REQ-034 Memory contents SHALL NOT be reset by reset_n; zeroing happens only through CLEAR.
REQ-035 Reset asserted mid-sweep or mid-read SHALL discard all in-flight reads, with no dout_valid after release for pre-reset requests.

Verification
All scenarios use DATA_WIDTH=32, ADDRESS_WIDTH=4, READ_LATENCY=3.
REQ-036 Scenario: release reset with CLEAR_ON_RESET=1 -> init_done=0 for 16 cycles then 1; read addr 5 -> dout=0x00000000 with dout_valid 3 cycles later.
REQ-037 Scenario: write 0xDEADBEEF to addr 3 with wbe=4'b1111 at t, read addr 3 at t+1 -> dout=0xDEADBEEF, dout_valid=1 at t+4 only.
REQ-038 Scenario: mem[7]=0x11223344; same cycle write din=0xAABBCCDD, wbe=4'b0101, addr 7, plus read addr 7 -> dout=0x11BB33DD; a later read returns the same value.
REQ-039 Scenario: after writing addrs 0..3 with 0xA0..0xA3, read 0,1,2,3 on consecutive cycles -> four consecutive dout_valid cycles with 0xA0, 0xA1, 0xA2, 0xA3.
REQ-040 Scenario: pulse clear_req in READY, with ren held high during CLEAR -> init_done=0 for 16 cycles, no dout_valid from requests issued in CLEAR, and a read of addr 3 afterwards returns 0.
REQ-041 Scenario: assert reset_n=0 one cycle after a read issue -> dout=0 and dout_valid=0 at once; after release, no dout_valid appears for that read.
